// File: rtl/craps_pkg.sv
// Shared types and constants for the craps round controller.
//   state_t  : round state, encoded to match the op output
//   SUM_*    : dice-sum constants for come-out decisions
//   is_point : 1 for sums that establish a point (4,5,6,8,9,10)
//   is_legal : 1 for sums within 2..12
package craps_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'b00,
        REROLL = 2'b01,
        WIN    = 2'b10,
        LOSE   = 2'b11
    } state_t;

    localparam int unsigned SUM_NATURAL_7 = 7;
    localparam int unsigned SUM_11        = 11;
    localparam int unsigned SUM_CRAPS_2   = 2;
    localparam int unsigned SUM_CRAPS_3   = 3;
    localparam int unsigned SUM_CRAPS_12  = 12;
    localparam int unsigned SUM_MIN       = 2;
    localparam int unsigned SUM_MAX       = 12;

    function automatic logic is_point(input int unsigned s);
        return (s == 4) || (s == 5) || (s == 6) ||
               (s == 8) || (s == 9) || (s == 10);
    endfunction

    function automatic logic is_legal(input int unsigned s);
        return (s >= SUM_MIN) && (s <= SUM_MAX);
    endfunction

endpackage

// File: rtl/craps_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   reset : synchronous reset, active-low (clears count)
//   clr   : synchronous clear, takes priority over inc
//   inc   : increment enable; count sticks at all-ones
//   count : current value
module craps_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/craps_round_fsm.sv
// Clocked craps round controller. Each roll strobe is evaluated against
// come-out or point-phase rules; the point is captured internally.
//   clk, reset  : rising-edge clock, synchronous active-low reset
//   roll, sum   : 1-cycle roll strobe and dice sum (legal 2..12)
//   op          : round state (00 INIT, 01 REROLL, 10 WIN, 11 LOSE)
//   point       : captured point, 0 when none held
//   point_valid : 1 while in REROLL
//   done        : 1-cycle pulse on every WIN/LOSE entry
//   err         : 1-cycle pulse on an illegal sum
//   wins/losses : saturating round-outcome tallies
//   reroll_cnt  : point-phase rolls this round (saturating)
module craps_round_fsm
    import craps_pkg::*;
#(
    parameter int          SUM_W       = 4,
    parameter int          CNT_W       = 8,
    parameter int          RC_W        = 8,
    parameter int unsigned MAX_REROLLS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             roll,
    input  logic [SUM_W-1:0] sum,
    output logic [1:0]       op,
    output logic [SUM_W-1:0] point,
    output logic             point_valid,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses,
    output logic [RC_W-1:0]  reroll_cnt
);

    state_t           state, state_n;
    logic [SUM_W-1:0] point_n;
    logic             done_n, err_n;
    logic             win_inc, loss_inc, rc_clr, rc_inc;
    int unsigned      sum_u;
    logic [RC_W-1:0]  rc_next;

    assign sum_u = 32'(sum);

    // Count value after this roll's increment, used for the reroll limit.
    assign rc_next = (reroll_cnt == '1) ? reroll_cnt : reroll_cnt + RC_W'(1);

    always_comb begin
        state_n  = state;
        point_n  = point;
        done_n   = 1'b0;
        err_n    = 1'b0;
        win_inc  = 1'b0;
        loss_inc = 1'b0;
        rc_clr   = 1'b0;
        rc_inc   = 1'b0;

        if (roll) begin
            if (!is_legal(sum_u)) begin
                err_n = 1'b1;
            end else if (state != REROLL) begin
                // INIT, WIN and LOSE all treat the roll as a fresh come-out.
                if (sum_u == SUM_NATURAL_7 || sum_u == SUM_11) begin
                    state_n = WIN;
                end else if (sum_u == SUM_CRAPS_2 || sum_u == SUM_CRAPS_3 ||
                             sum_u == SUM_CRAPS_12) begin
                    state_n = LOSE;
                end else if (is_point(sum_u)) begin
                    state_n = REROLL;
                    point_n = sum;
                    rc_clr  = 1'b1;
                end
            end else begin
                rc_inc = 1'b1;
                if (sum == point) begin
                    state_n = WIN;
                end else if (sum_u == SUM_NATURAL_7) begin
                    state_n = LOSE;
                end else if (MAX_REROLLS != 0 && 32'(rc_next) == MAX_REROLLS) begin
                    state_n = LOSE;
                end
            end

            // Any legal roll landing in WIN/LOSE is a new round outcome,
            // including WIN->WIN across consecutive come-outs.
            if (is_legal(sum_u) && (state_n == WIN || state_n == LOSE)) begin
                done_n   = 1'b1;
                win_inc  = (state_n == WIN);
                loss_inc = (state_n == LOSE);
                point_n  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= INIT;
            point       <= '0;
            point_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            point       <= point_n;
            point_valid <= (state_n == REROLL);
            done        <= done_n;
            err         <= err_n;
        end
    end

    assign op = state;

    craps_sat_counter #(.W(CNT_W)) u_wins (
        .clk(clk), .reset(reset), .clr(1'b0), .inc(win_inc), .count(wins)
    );

    craps_sat_counter #(.W(CNT_W)) u_losses (
        .clk(clk), .reset(reset), .clr(1'b0), .inc(loss_inc), .count(losses)
    );

    craps_sat_counter #(.W(RC_W)) u_reroll_cnt (
        .clk(clk), .reset(reset), .clr(rc_clr), .inc(rc_inc), .count(reroll_cnt)
    );

endmodule

// File: tb/tb_craps_round_fsm.sv
// Bench for craps_round_fsm: two instances (default parameters, and
// MAX_REROLLS=2 with CNT_W=2) see the same stimulus; expected outputs are
// pushed to a scoreboard as each cycle is driven and compared after the edge.
module tb_craps_round_fsm;

    logic       clk = 1'b0;
    logic       reset, roll;
    logic [3:0] sum;

    always #5 clk = ~clk;

    logic [1:0] a_op, b_op;
    logic [3:0] a_point, b_point;
    logic       a_pv, b_pv, a_done, b_done, a_err, b_err;
    logic [7:0] a_wins, a_losses, a_rc, b_rc;
    logic [1:0] b_wins, b_losses;

    craps_round_fsm #(.SUM_W(4), .CNT_W(8), .RC_W(8), .MAX_REROLLS(0)) dut_a (
        .clk(clk), .reset(reset), .roll(roll), .sum(sum),
        .op(a_op), .point(a_point), .point_valid(a_pv), .done(a_done), .err(a_err),
        .wins(a_wins), .losses(a_losses), .reroll_cnt(a_rc)
    );

    craps_round_fsm #(.SUM_W(4), .CNT_W(2), .RC_W(8), .MAX_REROLLS(2)) dut_b (
        .clk(clk), .reset(reset), .roll(roll), .sum(sum),
        .op(b_op), .point(b_point), .point_valid(b_pv), .done(b_done), .err(b_err),
        .wins(b_wins), .losses(b_losses), .reroll_cnt(b_rc)
    );

    typedef struct {
        int op, point, pv, done, err, wins, losses, rc;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } pair_t;

    pair_t sb[$];
    exp_t  ma, mb;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference round rules; maxr = reroll limit (0 = none), cmax = tally ceiling.
    function automatic exp_t model(input exp_t s, input logic rst, input logic rl,
                                   input int sm, input int maxr, input int cmax);
        exp_t n;
        n      = s;
        n.done = 0;
        n.err  = 0;
        if (!rst) begin
            n = '{default: 0};
            return n;
        end
        if (!rl) return n;
        if (sm < 2 || sm > 12) begin
            n.err = 1;
            return n;
        end
        if (s.op == 1) begin
            n.rc = (s.rc < 255) ? s.rc + 1 : 255;
            if (sm == s.point)                   n.op = 2;
            else if (sm == 7)                    n.op = 3;
            else if (maxr != 0 && n.rc == maxr)  n.op = 3;
        end else if (sm == 7 || sm == 11) begin
            n.op = 2;
        end else if (sm == 2 || sm == 3 || sm == 12) begin
            n.op = 3;
        end else begin
            n.op    = 1;
            n.point = sm;
            n.rc    = 0;
        end
        n.pv = (n.op == 1) ? 1 : 0;
        if (n.op >= 2) begin
            n.point = 0;
            n.done  = 1;
            if (n.op == 2) n.wins   = (s.wins   < cmax) ? s.wins + 1   : cmax;
            else           n.losses = (s.losses < cmax) ? s.losses + 1 : cmax;
        end
        return n;
    endfunction

    task automatic step(input logic r, input logic rl, input int sm);
        pair_t e;
        @(negedge clk);
        reset = r;
        roll  = rl;
        sum   = 4'(sm);
        ma = model(ma, r, rl, sm, 0, 255);
        mb = model(mb, r, rl, sm, 2, 3);
        sb.push_back('{a: ma, b: mb});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("a_op",     32'(a_op),     e.a.op);
            chk("a_point",  32'(a_point),  e.a.point);
            chk("a_pv",     32'(a_pv),     e.a.pv);
            chk("a_done",   32'(a_done),   e.a.done);
            chk("a_err",    32'(a_err),    e.a.err);
            chk("a_wins",   32'(a_wins),   e.a.wins);
            chk("a_losses", 32'(a_losses), e.a.losses);
            chk("a_rc",     32'(a_rc),     e.a.rc);
            chk("b_op",     32'(b_op),     e.b.op);
            chk("b_point",  32'(b_point),  e.b.point);
            chk("b_pv",     32'(b_pv),     e.b.pv);
            chk("b_done",   32'(b_done),   e.b.done);
            chk("b_err",    32'(b_err),    e.b.err);
            chk("b_wins",   32'(b_wins),   e.b.wins);
            chk("b_losses", 32'(b_losses), e.b.losses);
            chk("b_rc",     32'(b_rc),     e.b.rc);
        end
    endtask

    initial begin
        reset = 1'b1;
        roll  = 1'b0;
        sum   = '0;
        ma    = '{default: 0};
        mb    = '{default: 0};

        // Reset wins over a simultaneous natural.
        step(0, 1, 7);
        chk("t1_rst_op", 32'(a_op), 0);
        step(1, 0, 0);
        step(1, 1, 7);
        chk("t1_win_op", 32'(a_op), 2);
        chk("t1_wins", 32'(a_wins), 1);
        step(1, 0, 0);
        chk("t1_done_clr", 32'(a_done), 0);

        // Point made.
        step(1, 1, 6);
        chk("t2_point", 32'(a_point), 6);
        step(1, 1, 8);
        chk("t2_rc", 32'(a_rc), 1);
        step(1, 1, 6);
        chk("t2_wins", 32'(a_wins), 2);

        // Seven-out, then immediate come-out natural.
        step(1, 1, 4);
        step(1, 1, 7);
        chk("t3_losses", 32'(a_losses), 1);
        step(1, 1, 11);
        chk("t3_comeout", 32'(a_op), 2);

        // Reroll limit on dut_b only.
        step(1, 1, 5);
        step(1, 1, 9);
        step(1, 1, 9);
        chk("t4_b_lose", 32'(b_op), 3);
        chk("t4_a_stay", 32'(a_op), 1);

        // Illegal sums in come-out (b) and point phase (a).
        step(1, 1, 13);
        step(1, 1, 0);
        step(1, 1, 15);
        step(1, 1, 1);
        step(1, 1, 5);
        step(1, 1, 13);
        chk("t5_b_err", 32'(b_err), 1);
        step(1, 1, 7);

        // Tally saturation on the 2-bit instance.
        step(1, 1, 7);
        step(1, 1, 11);
        step(1, 1, 7);
        step(1, 1, 7);
        chk("t6_sat", 32'(b_wins), 3);
        step(1, 1, 6);
        step(0, 0, 0);
        chk("t6_rst_wins", 32'(a_wins), 0);
        step(1, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 50) != 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
